// File: rtl/edge_arb_pkg.sv
// rtl/edge_arb_pkg.sv - shared constants and slot-index helpers for the edge event arbiter
package edge_arb_pkg;

   localparam int N_CH_DEF   = 4;
   localparam int CH_W_DEF   = 2;
   localparam int DROP_W_DEF = 8;
   localparam int TS_W_DEF   = 16;
   localparam int N_SLOT     = 2 * N_CH_DEF;

   localparam logic POL_RISE = 1'b1;
   localparam logic POL_FALL = 1'b0;

   // each channel owns an adjacent slot pair: rise first, fall second
   localparam int SLOT_RISE_OFS = 0;
   localparam int SLOT_FALL_OFS = 1;

   function automatic int slot_of(input int ch, input logic pol);
      return 2 * ch + ((pol == POL_RISE) ? SLOT_RISE_OFS : SLOT_FALL_OFS);
   endfunction

endpackage

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - one monitored channel: previous-value register and enable-masked edge outputs
module edge_chan (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   input  logic rise_en,
   input  logic fall_en,
   output logic rise,
   output logic fall
);

   logic prev_q;
   logic prev_d;

   // prev tracks sig_in unconditionally so re-enabling never reports a stale edge
   always_comb prev_d = sig_in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_q <= 1'b0;
      else      prev_q <= prev_d;
   end

   assign rise = sig_in & ~prev_q & rise_en;
   assign fall = ~sig_in & prev_q & fall_en;

endmodule

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - edge detection bank with round-robin event serialiser and drop counter
// Optional per-event timestamps: define EDGE_ARB_TIMESTAMP_EN.
module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter int N_CH   = N_CH_DEF,
   parameter int CH_W   = CH_W_DEF,
   parameter int DROP_W = DROP_W_DEF
`ifdef EDGE_ARB_TIMESTAMP_EN
   ,parameter int TS_W  = TS_W_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   sig_in,
   input  logic [N_CH-1:0]   rise_en,
   input  logic [N_CH-1:0]   fall_en,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CH_W-1:0]   evt_ch,
   output logic              evt_pol,
`ifdef EDGE_ARB_TIMESTAMP_EN
   output logic [TS_W-1:0]   evt_ts,
`endif
   output logic [DROP_W-1:0] drop_cnt,
   input  logic              drop_clr,
   output logic              busy
);

   localparam int NS    = 2 * N_CH;
   localparam int SW    = CH_W + 1;
   localparam int SUM_W = DROP_W + $clog2(NS + 1);

   logic [N_CH-1:0]   rise;
   logic [N_CH-1:0]   fall;
   logic [NS-1:0]     set_v;
   logic [NS-1:0]     slot_en;

   logic [NS-1:0]     pending_q, pending_d;
   logic [SW-1:0]     rr_q, rr_d;
   logic              evt_valid_q, evt_valid_d;
   logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
   logic              evt_pol_q, evt_pol_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic              load;
   logic              found;
   logic [SW-1:0]     gidx;
   logic [SW-1:0]     s_idx;
   logic [NS-1:0]     grant;
   logic [NS-1:0]     drop_v;
   logic [SUM_W-1:0]  drop_sum;

   for (genvar c = 0; c < N_CH; c++) begin : g_chan
      edge_chan u_chan (
         .clk     (clk),
         .rst     (rst),
         .sig_in  (sig_in[c]),
         .rise_en (rise_en[c]),
         .fall_en (fall_en[c]),
         .rise    (rise[c]),
         .fall    (fall[c])
      );
      assign set_v[slot_of(c, POL_RISE)]   = rise[c];
      assign set_v[slot_of(c, POL_FALL)]   = fall[c];
      assign slot_en[slot_of(c, POL_RISE)] = rise_en[c];
      assign slot_en[slot_of(c, POL_FALL)] = fall_en[c];
   end

   // first pending slot at or after the pointer, only when the output register can take it
   always_comb begin
      load  = ~evt_valid_q | evt_ready;
      found = 1'b0;
      gidx  = '0;
      s_idx = '0;
      for (int k = 0; k < NS; k++) begin
         s_idx = SW'((int'(rr_q) + k) % NS);
         if (load && !found && pending_q[s_idx]) begin
            found = 1'b1;
            gidx  = s_idx;
         end
      end
      grant = '0;
      if (found) grant[gidx] = 1'b1;
   end

   // a fresh edge on the granted slot re-arms it rather than being lost
   always_comb begin
      pending_d = ((pending_q & ~grant) | set_v) & slot_en;
      drop_v    = set_v & pending_q & ~grant;

      drop_sum = drop_clr ? '0 : SUM_W'(drop_cnt_q);
      for (int s = 0; s < NS; s++) drop_sum = drop_sum + SUM_W'(drop_v[s]);
      drop_cnt_d = (|drop_sum[SUM_W-1:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];

      evt_valid_d = evt_valid_q;
      evt_ch_d    = evt_ch_q;
      evt_pol_d   = evt_pol_q;
      rr_d        = rr_q;
      if (load) begin
         evt_valid_d = found;
         if (found) begin
            evt_ch_d  = gidx[SW-1:1];
            evt_pol_d = (gidx[0] == SLOT_RISE_OFS[0]) ? POL_RISE : POL_FALL;
            rr_d      = (gidx == SW'(NS - 1)) ? '0 : gidx + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q   <= '0;
         rr_q        <= '0;
         evt_valid_q <= 1'b0;
         evt_ch_q    <= '0;
         evt_pol_q   <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         pending_q   <= pending_d;
         rr_q        <= rr_d;
         evt_valid_q <= evt_valid_d;
         evt_ch_q    <= evt_ch_d;
         evt_pol_q   <= evt_pol_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

`ifdef EDGE_ARB_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q, ts_d;
   logic [TS_W-1:0] slot_ts_q [NS];
   logic [TS_W-1:0] slot_ts_d [NS];
   logic [TS_W-1:0] evt_ts_q, evt_ts_d;

   always_comb begin
      ts_d      = ts_q + TS_W'(1);
      slot_ts_d = slot_ts_q;
      for (int s = 0; s < NS; s++) begin
         if (set_v[s]) slot_ts_d[s] = ts_q;
      end
      evt_ts_d = evt_ts_q;
      if (load && found) evt_ts_d = slot_ts_q[gidx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_q      <= '0;
         slot_ts_q <= '{default: '0};
         evt_ts_q  <= '0;
      end else begin
         ts_q      <= ts_d;
         slot_ts_q <= slot_ts_d;
         evt_ts_q  <= evt_ts_d;
      end
   end

   assign evt_ts = evt_ts_q;
`endif

   assign evt_valid = evt_valid_q;
   assign evt_ch    = evt_ch_q;
   assign evt_pol   = evt_pol_q;
   assign drop_cnt  = drop_cnt_q;
   assign busy      = (|pending_q) | evt_valid_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - directed and randomized bench for edge_event_arbiter
module tb_edge_event_arbiter;

   localparam int NC = 4;
   localparam int NS = 2 * NC;

   logic          clk = 1'b0;
   logic          rst;
   logic [NC-1:0] sig_in;
   logic [NC-1:0] rise_en;
   logic [NC-1:0] fall_en;
   logic          evt_valid;
   logic          evt_ready;
   logic [1:0]    evt_ch;
   logic          evt_pol;
   logic [7:0]    drop_cnt;
   logic          drop_clr;
   logic          busy;
`ifdef EDGE_ARB_TIMESTAMP_EN
   logic [15:0]   evt_ts;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // reference state: the event stream as the rules describe it
   bit m_prev [NC];
   bit m_pend [NS];
   int m_rr;
   bit m_valid;
   int m_ch;
   bit m_pol;
   int m_drop;

   always #5 clk = ~clk;

   edge_event_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in),
      .rise_en   (rise_en),
      .fall_en   (fall_en),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_ch    (evt_ch),
      .evt_pol   (evt_pol),
`ifdef EDGE_ARB_TIMESTAMP_EN
      .evt_ts    (evt_ts),
`endif
      .drop_cnt  (drop_cnt),
      .drop_clr  (drop_clr),
      .busy      (busy)
   );

   task automatic model_reset();
      for (int c = 0; c < NC; c++) m_prev[c] = 1'b0;
      for (int s = 0; s < NS; s++) m_pend[s] = 1'b0;
      m_rr = 0; m_valid = 1'b0; m_ch = 0; m_pol = 1'b0; m_drop = 0;
   endtask

   task automatic model_step();
      int  g;
      int  drops;
      int  c;
      bit  ld, e, en, rising;
      bit  np [NS];
      ld = !m_valid || evt_ready;
      g  = -1;
      if (ld) begin
         for (int k = 0; k < NS; k++) begin
            int s;
            s = (m_rr + k) % NS;
            if (g < 0 && m_pend[s]) g = s;
         end
      end
      drops = 0;
      for (int s = 0; s < NS; s++) begin
         c      = s / 2;
         rising = (s % 2 == 0);
         e  = rising ? (sig_in[c] && !m_prev[c]) : (!sig_in[c] && m_prev[c]);
         en = rising ? rise_en[c] : fall_en[c];
         if (e && en && m_pend[s] && s != g) drops++;
         np[s] = en && ((e && en) || (m_pend[s] && s != g));
      end
      if (drop_clr) m_drop = 0;
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
      if (ld) begin
         if (g >= 0) begin
            m_valid = 1'b1; m_ch = g / 2; m_pol = (g % 2 == 0); m_rr = (g + 1) % NS;
         end else begin
            m_valid = 1'b0;
         end
      end
      for (int k = 0; k < NC; k++) m_prev[k] = sig_in[k];
      for (int s = 0; s < NS; s++) m_pend[s] = np[s];
   endtask

   function automatic bit m_busy();
      bit b;
      b = m_valid;
      for (int s = 0; s < NS; s++) b |= m_pend[s];
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      if (!rst) model_reset();
      else      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; sig_in = '0; rise_en = '1; fall_en = '1; evt_ready = 1'b1; drop_clr = 1'b0;
      model_reset();
      step(); step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0;
      step(); step();
      n_checks++;
      if (evt_valid !== 1'b0 || drop_cnt !== 8'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: valid=%0b drop=%0d busy=%0b, required 0/0/0", evt_valid, drop_cnt, busy);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_async_reset();
      do_reset();
      evt_ready = 1'b0;
      sig_in = 4'b0010;
      step(); step();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL async_pre: valid=%0b ch=%0d busy=%0b, required 1/1/1", evt_valid, evt_ch, busy);
      end
      #3 rst = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (evt_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_immediate: valid=%0b busy=%0b, required 0/0", evt_valid, busy);
      end
      sig_in = '0;
      step();
      rst = 1'b1;
      evt_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_after cyc %0d: valid=%0b, required 0", i, evt_valid);
         end
      end
   endtask

   task automatic test_single_edge();
      do_reset();
      sig_in[2] = 1'b1;
      step();
      n_checks++;
      if (evt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early: valid=%0b, required 0", evt_valid);
      end
      step();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_pol !== 1'b1) begin
         n_fail++;
         $display("FAIL single_event: valid=%0b ch=%0d pol=%0b, required 1/2/1", evt_valid, evt_ch, evt_pol);
      end
      step();
      n_checks++;
      if (evt_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_once: valid=%0b busy=%0b, required 0/0", evt_valid, busy);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      sig_in = 4'b1111;
      step();
      for (int i = 0; i < NC; i++) begin
         step();
         n_checks++;
         if (evt_valid !== 1'b1 || evt_ch !== 2'(i) || evt_pol !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_ev%0d: valid=%0b ch=%0d pol=%0b, required 1/%0d/1", i, evt_valid, evt_ch, evt_pol, i);
         end
      end
      step();
      n_checks++;
      if (evt_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_idle: valid=%0b busy=%0b, required 0/0", evt_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      evt_ready = 1'b0;
      sig_in = 4'b0001;
      step(); step();
      sig_in = 4'b0011; step();
      sig_in = 4'b0001; step();
      sig_in = 4'b0011; step();
      n_checks++;
      if (drop_cnt !== 8'd1 || evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pol !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_overflow: drop=%0d valid=%0b ch=%0d pol=%0b, required 1/1/0/1", drop_cnt, evt_valid, evt_ch, evt_pol);
      end
      evt_ready = 1'b1;
      step();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ch1_rise: valid=%0b ch=%0d pol=%0b, required 1/1/1", evt_valid, evt_ch, evt_pol);
      end
      step();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_ch1_fall: valid=%0b ch=%0d pol=%0b, required 1/1/0", evt_valid, evt_ch, evt_pol);
      end
      step();
      n_checks++;
      if (evt_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_idle: valid=%0b busy=%0b, required 0/0", evt_valid, busy);
      end
   endtask

   task automatic test_masking();
      int n_ev, n_bad, n_ch3;
      do_reset();
      fall_en = 4'b1110;
      n_ev = 0; n_bad = 0;
      for (int i = 0; i < 9; i++) begin
         sig_in[0] = (i < 3);
         step();
         if (evt_valid) begin
            n_ev++;
            if (evt_ch !== 2'd0 || evt_pol !== 1'b1) n_bad++;
         end
      end
      n_checks++;
      if (n_ev != 1 || n_bad != 0) begin
         n_fail++;
         $display("FAIL mask_fall: events=%0d wrong=%0d, required 1/0", n_ev, n_bad);
      end
      fall_en = '1;
      evt_ready = 1'b0;
      sig_in[2] = 1'b1; step(); step();
      sig_in[3] = 1'b1; step();
      rise_en[3] = 1'b0; step();
      rise_en[3] = 1'b1;
      n_checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd2) begin
         n_fail++;
         $display("FAIL mask_hold: valid=%0b ch=%0d, required 1/2", evt_valid, evt_ch);
      end
      evt_ready = 1'b1;
      n_ch3 = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (evt_valid && evt_ch === 2'd3) n_ch3++;
      end
      n_checks++;
      if (n_ch3 != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_rise3: ch3 events=%0d busy=%0b, required 0/0", n_ch3, busy);
      end
   endtask

   task automatic test_drop_counter();
      do_reset();
      evt_ready = 1'b0;
      for (int i = 0; i < 320; i++) begin
         sig_in[0] = ~sig_in[0];
         step();
         if (i == 20) begin
            n_checks++;
            if (drop_cnt !== 8'(m_drop)) begin
               n_fail++;
               $display("FAIL drop_count: drop=%0d, required %0d", drop_cnt, m_drop);
            end
         end
      end
      n_checks++;
      if (drop_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL drop_saturate: drop=%0d, required 255", drop_cnt);
      end
      drop_clr = 1'b1;
      sig_in[0] = ~sig_in[0];
      step();
      drop_clr = 1'b0;
      n_checks++;
      if (drop_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL drop_clr_with_drop: drop=%0d, required 1", drop_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         sig_in   = sig_in ^ (4'($urandom) & 4'($urandom));
         if ($urandom_range(0, 15) == 0) rise_en = 4'($urandom);
         if ($urandom_range(0, 15) == 0) fall_en = 4'($urandom);
         if ($urandom_range(0, 15) == 0) begin rise_en = '1; fall_en = '1; end
         evt_ready = ($urandom_range(0, 3) != 0);
         drop_clr  = ($urandom_range(0, 63) == 0);
         step();
         n_checks++;
         if (evt_valid !== m_valid || (m_valid && (evt_ch !== 2'(m_ch) || evt_pol !== m_pol)) ||
             drop_cnt !== 8'(m_drop) || busy !== m_busy()) begin
            n_fail++;
            $display("FAIL random cyc %0d: dut v=%0b ch=%0d pol=%0b drop=%0d busy=%0b, model v=%0b ch=%0d pol=%0b drop=%0d busy=%0b",
                     i, evt_valid, evt_ch, evt_pol, drop_cnt, busy, m_valid, m_ch, m_pol, m_drop, m_busy());
         end
      end
      drop_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0; sig_in = '0; rise_en = '1; fall_en = '1; evt_ready = 1'b1; drop_clr = 1'b0;
      model_reset();
      test_reset();
      test_single_edge();
      test_async_reset();
      test_simultaneous();
      test_backpressure();
      test_masking();
      test_drop_counter();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Controller for a bank of N_CH edge-detector channels (4-bit signal input).
- Detects rising and falling edges per channel, gated by per-channel enables, and holds each as a pending event.
- A round-robin arbiter serialises pending events onto one valid/ready event port toward the interrupt/logging logic.
- Counts events lost to overflow.

Parameters:
- N_CH, 4: number of monitored input signals.
- CH_W, 2: channel index width, equal to clog2(N_CH).
- DROP_W, 8: width of the drop counter.
- TS_W, 16: timestamp width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- sig_in  in  N_CH  monitored signals; synchronous to clk, no synchroniser inside.
- rise_en  in  N_CH  per-channel rising-edge enable.
- fall_en  in  N_CH  per-channel falling-edge enable.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_ch  out  CH_W  channel of the event.
- evt_pol  out  1  1 = rising, 0 = falling.
- drop_cnt  out  DROP_W  saturating count of dropped events.
- drop_clr  in  1  synchronous clear of drop_cnt.
- busy  out  1  any slot pending, or evt_valid high.

Behaviour:
- Reset (rst=0, asynchronous): prev register, pending slots, RR pointer, evt_valid, evt_ch, evt_pol and drop_cnt all go to 0; busy=0.
- Edge detection, per channel c:
  - prev[c] is updated with sig_in[c] every cycle.
  - rise = sig_in & ~prev; fall = ~sig_in & prev.
  - prev resets to 0, so a high sig_in at reset release yields a rising edge.
- Slots: 2*N_CH pending bits. Slot 2c = rise of channel c; slot 2c+1 = fall of channel c.
- Slot set: a qualified edge (edge & enable) seen at edge N sets the slot at edge N.
- Enable deasserted: a slot whose enable is 0 is cleared and never sets. prev keeps tracking regardless of enables.
- Output register loads when evt_valid=0 or (evt_valid & evt_ready), so an accept and a new load can happen in the same cycle.
  - Load picks the first pending slot at or after the RR pointer, wrapping modulo 2*N_CH.
  - The granted slot is cleared.
  - The pointer moves to granted+1.
- Latency: edge sampled at clock N leads to evt_valid high after clock N+1 when the output register is free.
- Throughput: one event per cycle.
- Hold: while evt_valid & ~evt_ready, evt_ch and evt_pol are stable.
- No event pending at load time: evt_valid drops to 0 after an accept.
- Simultaneous set and grant on the same slot: set wins; the slot stays pending.
- Overflow: a qualified edge on a slot that is already pending and not granted that cycle is dropped; drop_cnt increments and saturates at all-ones.
- drop_clr coinciding with a drop: drop_cnt becomes 1.
- Reset mid-operation: all pending events and the output event are discarded immediately.

Optional Feature:
- Macro: EDGE_ARB_TIMESTAMP_EN.
- Defined:
  - A free-running TS_W counter runs from 0 after reset and wraps.
  - Each slot captures the counter value in the cycle the slot sets.
  - Output port evt_ts[TS_W-1:0] is loaded with the event and follows the same hold rules.
  - Set-wins-over-grant recaptures the timestamp.
- Undefined: no counter, no per-slot timestamp storage, no evt_ts port.

Decomposition:
- Package edge_arb_pkg holds:
  - N_SLOT = 2*N_CH.
  - POL_RISE = 1'b1, POL_FALL = 1'b0.
  - Slot-index helper constants.
  - Default widths.
- Sub-module edge_chan, instantiated N_CH times: prev register plus enable-masked rise/fall outputs.
- Arbiter, pending slots, output register and drop counter stay in the top module.

Test Plan:
1. Reset, and async reset mid-run:
   - Hold rst=0 → evt_valid=0, drop_cnt=0, busy=0.
   - With ch1 pending, pull rst low between clock edges → evt_valid=0 immediately; no events after release with sig_in=0.
2. Single edge:
   - All enables 1, evt_ready=1; sig_in[2] goes 0→1 before clock N.
   - → evt_valid=1, evt_ch=2, evt_pol=1 after clock N+1, for exactly one cycle.
3. Simultaneous edges:
   - sig_in goes 0000→1111 in one cycle with pointer at 0.
   - → events ch0, ch1, ch2, ch3 (all pol=1) in four consecutive cycles; then evt_valid=0, busy=0.
4. Backpressure and overflow:
   - evt_ready=0; ch0 rise occupies the output; then ch1 toggles 0→1→0→1 on successive cycles.
   - → drop_cnt=1.
   - Raise evt_ready → ch0 rise, ch1 rise, ch1 fall, then idle.
5. Masking:
   - fall_en[0]=0; pulse sig_in[0] high for 3 cycles → only ch0 rise is reported.
   - Clear rise_en[3] while ch3 rise is pending → it is never reported.
6. Drop counter:
   - Force 300 drops → drop_cnt=255 (saturated).
   - Pulse drop_clr in the same cycle as a drop → drop_cnt=1.
